datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
Instruction sequencer that drives the control side of the register-file/ALU datapath (Sel, Wen, WA, RAA, RAB, Op, Ctrl) and consumes its Flag output. It fetches 24-bit instructions from a synchronous program ROM, decodes them, and issues one datapath operation per instruction. It also handles conditional branches on Flag, timed waits and halt. A start/busy/done handshake connects it to the testbench or host.

Parameters:
PC_W, 8, program counter / ROM address width
WAIT_W, 8, width of the WAIT cycle-count field (= instr[7:0])

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to run the program from address 0
abort  in  1  synchronous stop; returns to IDLE
busy  out  1  high from the cycle after start is accepted until return to IDLE
done  out  1  one-cycle pulse when HALT executes
instr_addr  out  PC_W  ROM address
instr_rd  out  1  ROM read strobe; data valid on instr_data the following cycle
instr_data  in  24  ROM read data
Flag  in  1  datapath flag, valid from the cycle after an ALU issue
Op  out  3  datapath operation
WA  out  4  write address
RAA  out  4  read address A
RAB  out  4  read address B
Sel  out  4  input-port nibble select
Ctrl  out  8  raw copy of instr[7:0] of the current instruction
Wen  out  1  register write enable, single-cycle pulse

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; pc=0; busy, done, instr_rd, Wen = 0; Op, WA, RAA, RAB, Sel, Ctrl, instr_addr = 0. Reset overrides start and abort.
- Instruction fields: kind=[23:21]; Op=[20:18]; WA=[17:14]; RAA=[13:10]; RAB=[9:6]; we=[5]; target/count=[7:0].
- Kinds:
  - 000 ALU: drive Op/WA/RAA/RAB; Wen=we.
  - 001 IN: WA=[17:14], Sel=[13:10], Op=100, Wen=1.
  - 010 BRF: pc<=target if Flag=1, else pc+1.
  - 011 JMP: pc<=target.
  - 100 WAIT: stall count cycles.
  - 111 HALT.
  - 101/110: NOP.
- States:
  - IDLE: start=1 → FETCH, pc<=0, busy<=1. start while busy is ignored.
  - FETCH: instr_addr=pc, instr_rd=1 for exactly one cycle → EXEC.
  - EXEC: decode instr_data and register the datapath fields in this cycle. Wen is high for this cycle only. pc<=pc+1 unless a taken branch/jump applies. Next state: WAIT→WAIT if count≠0, HALT→IDLE with done=1 and busy<=0, otherwise FETCH.
  - WAIT: counter loaded with count-1; decrement each cycle; →FETCH when it reads 0. Total stall = count cycles.
- Throughput: 2 cycles per instruction without a wait.
- Op/WA/RAA/RAB/Sel/Ctrl hold their last EXEC value in all other states. Outputs change only in EXEC, so the datapath sees stable controls between issues.
- Only ALU and IN ever assert Wen; BRF, JMP, WAIT, HALT and NOP leave the held fields unchanged with Wen=0.
- Flag is sampled in EXEC of BRF. The intervening FETCH cycle guarantees Flag reflects the previous ALU issue.
- pc arithmetic is modulo 2^PC_W: 255+1 wraps to 0 for PC_W=8. No error is raised.
- abort=1 in any non-IDLE state → IDLE next cycle. busy<=0, Wen forced 0 that cycle, no done pulse, pc unchanged until the next start.
- abort and start in the same cycle while IDLE: abort wins, stay IDLE.
- done and busy never high in the same cycle; done is high in the first IDLE cycle.

Test Plan:
- Reset mid-WAIT (count=0x20, rst_n=0 after 5 cycles) → next cycle IDLE, all outputs 0, pc=0; a following start fetches address 0.
- ROM{0:ALU Op=000 WA=3 RAA=1 RAB=2 we=1; 1:HALT}, start → Wen high exactly at cycle 2 after start with Op=000 WA=3 RAA=1 RAB=2; done pulses once at cycle 4; busy low afterward.
- ROM{0:ALU Op=010 we=0; 1:BRF target=0x10; 0x10:HALT}, Flag=1 → instr_addr sequence 0,1,0x10; Wen never asserted; Flag=0 variant → address 2 fetched.
- WAIT count=5 between two ALUs → exactly 5 cycles between the EXEC leaving WAIT and the next FETCH; count=0 → no stall (2-cycle spacing).
- JMP target=0xFF, instr at 0xFF = IN WA=7 Sel=0xA → Wen=1 with Sel=0xA, Op=100; next fetch address 0x00 (wrap).
- abort asserted during FETCH of a HALT program → IDLE next cycle, busy=0, no done pulse, Wen=0; start accepted in the following cycle.

Source files
------------

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetches 24-bit instructions from a synchronous ROM
// and issues one register-file/ALU operation per instruction.
// Ports: clk, rst_n (sync, active low); start/abort in, busy/done out;
// instr_addr/instr_rd out, instr_data in (ROM, 1-cycle latency);
// Flag in; Op/WA/RAA/RAB/Sel/Ctrl/Wen datapath controls out.
module datapath_sequencer #(
    parameter int PC_W   = 8,
    parameter int WAIT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] instr_addr,
    output logic            instr_rd,
    input  logic [23:0]     instr_data,
    input  logic            Flag,
    output logic [2:0]      Op,
    output logic [3:0]      WA,
    output logic [3:0]      RAA,
    output logic [3:0]      RAB,
    output logic [3:0]      Sel,
    output logic [7:0]      Ctrl,
    output logic            Wen
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT
    } state_t;

    localparam logic [2:0] K_ALU  = 3'b000;
    localparam logic [2:0] K_IN   = 3'b001;
    localparam logic [2:0] K_BRF  = 3'b010;
    localparam logic [2:0] K_JMP  = 3'b011;
    localparam logic [2:0] K_WAIT = 3'b100;
    localparam logic [2:0] K_HALT = 3'b111;

    state_t              r_state, w_state_nx;
    logic [PC_W-1:0]     r_pc, w_pc_nx;
    logic [WAIT_W-1:0]   r_cnt, w_cnt_nx;
    logic                r_busy, w_busy_nx;
    logic                r_done, w_done_nx;
    logic                r_wen, w_wen_nx;
    logic [2:0]          r_op, w_op_nx;
    logic [3:0]          r_wa, w_wa_nx;
    logic [3:0]          r_raa, w_raa_nx;
    logic [3:0]          r_rab, w_rab_nx;
    logic [3:0]          r_sel, w_sel_nx;
    logic [7:0]          r_ctrl, w_ctrl_nx;

    logic [2:0]          w_kind;
    logic [PC_W-1:0]     w_target;
    logic [WAIT_W-1:0]   w_count;
    logic                w_abort;

    assign w_kind   = instr_data[23:21];
    assign w_target = PC_W'(instr_data[7:0]);
    assign w_count  = instr_data[WAIT_W-1:0];
    assign w_abort  = abort && (r_state != S_IDLE);

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_cnt_nx   = r_cnt;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_wen_nx   = 1'b0;
        w_op_nx    = r_op;
        w_wa_nx    = r_wa;
        w_raa_nx   = r_raa;
        w_rab_nx   = r_rab;
        w_sel_nx   = r_sel;
        w_ctrl_nx  = r_ctrl;
        unique case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nx = S_FETCH;
                    w_pc_nx    = '0;
                    w_busy_nx  = 1'b1;
                end
            end
            S_FETCH: w_state_nx = S_EXEC;
            S_EXEC: begin
                w_state_nx = S_FETCH;
                w_pc_nx    = r_pc + PC_W'(1);
                unique case (w_kind)
                    K_ALU: begin
                        w_op_nx   = instr_data[20:18];
                        w_wa_nx   = instr_data[17:14];
                        w_raa_nx  = instr_data[13:10];
                        w_rab_nx  = instr_data[9:6];
                        w_ctrl_nx = instr_data[7:0];
                        w_wen_nx  = instr_data[5];
                    end
                    K_IN: begin
                        w_op_nx   = 3'b100;
                        w_wa_nx   = instr_data[17:14];
                        w_sel_nx  = instr_data[13:10];
                        w_ctrl_nx = instr_data[7:0];
                        w_wen_nx  = 1'b1;
                    end
                    K_BRF: begin
                        if (Flag) w_pc_nx = w_target;
                    end
                    K_JMP: w_pc_nx = w_target;
                    K_WAIT: begin
                        if (w_count != '0) begin
                            w_state_nx = S_WAIT;
                            w_cnt_nx   = w_count - WAIT_W'(1);
                        end
                    end
                    K_HALT: begin
                        w_state_nx = S_IDLE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WAIT: begin
                if (r_cnt == '0) w_state_nx = S_FETCH;
                else             w_cnt_nx   = r_cnt - WAIT_W'(1);
            end
            default: w_state_nx = S_IDLE;
        endcase
        // abort discards whatever this cycle would have issued
        if (w_abort) begin
            w_state_nx = S_IDLE;
            w_pc_nx    = r_pc;
            w_cnt_nx   = r_cnt;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b0;
            w_wen_nx   = 1'b0;
            w_op_nx    = r_op;
            w_wa_nx    = r_wa;
            w_raa_nx   = r_raa;
            w_rab_nx   = r_rab;
            w_sel_nx   = r_sel;
            w_ctrl_nx  = r_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wen   <= 1'b0;
            r_op    <= '0;
            r_wa    <= '0;
            r_raa   <= '0;
            r_rab   <= '0;
            r_sel   <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_wen   <= w_wen_nx;
            r_op    <= w_op_nx;
            r_wa    <= w_wa_nx;
            r_raa   <= w_raa_nx;
            r_rab   <= w_rab_nx;
            r_sel   <= w_sel_nx;
            r_ctrl  <= w_ctrl_nx;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign instr_addr = r_pc;
    assign instr_rd   = (r_state == S_FETCH);
    assign Op         = r_op;
    assign WA         = r_wa;
    assign RAA        = r_raa;
    assign RAB        = r_rab;
    assign Sel        = r_sel;
    assign Ctrl       = r_ctrl;
    // an abort in the issue cycle suppresses the pending write
    assign Wen        = r_wen && !w_abort;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed programs with hand-computed
// fetch/issue timing for datapath_sequencer.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, busy, done, instr_rd, Flag, Wen;
    logic [7:0]  instr_addr;
    logic [23:0] instr_data;
    logic [2:0]  Op;
    logic [3:0]  WA, RAA, RAB, Sel;
    logic [7:0]  Ctrl;
    logic [23:0] rom [256];

    int n_cmp = 0;
    int n_bad = 0;

    int addrs[$];
    int fcyc[$];
    int wen_n, wen_cyc, done_n, done_cyc, both;
    int s_op, s_wa, s_raa, s_rab, s_sel, s_ctrl;

    always #5 clk = ~clk;

    always @(posedge clk) if (instr_rd) instr_data <= rom[instr_addr];

    datapath_sequencer #(.PC_W(8), .WAIT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .instr_addr(instr_addr),
        .instr_rd(instr_rd), .instr_data(instr_data), .Flag(Flag),
        .Op(Op), .WA(WA), .RAA(RAA), .RAB(RAB), .Sel(Sel),
        .Ctrl(Ctrl), .Wen(Wen)
    );

    function automatic logic [23:0] i_alu(input logic [2:0] op,
        input logic [3:0] wa, input logic [3:0] raa,
        input logic [3:0] rab, input logic we);
        return {3'b000, op, wa, raa, rab, we, 5'b0};
    endfunction

    function automatic logic [23:0] i_in(input logic [3:0] wa,
        input logic [3:0] sel);
        return {3'b001, 3'b000, wa, sel, 10'b0};
    endfunction

    function automatic logic [23:0] i_k(input logic [2:0] k,
        input logic [7:0] t);
        return {k, 13'b0, t};
    endfunction

    function automatic int qa(input int k);
        return (k < addrs.size()) ? addrs[k] : -1;
    endfunction

    function automatic int qc(input int k);
        return (k < fcyc.size()) ? fcyc[k] : -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
        input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_prog();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 24'h0;
    endtask

    // index 0 is the first cycle after the start edge (FETCH of addr 0)
    task automatic run(input int maxc);
        addrs.delete();
        fcyc.delete();
        wen_n = 0; wen_cyc = -1; done_n = 0; done_cyc = -1; both = 0;
        for (int i = 0; i < maxc; i++) begin
            if (i > 0) step();
            if (instr_rd) begin
                addrs.push_back(int'(instr_addr));
                fcyc.push_back(i);
            end
            if (Wen) begin
                wen_n++;
                if (wen_cyc < 0) begin
                    wen_cyc = i;
                    s_op = int'(Op); s_wa = int'(WA);
                    s_raa = int'(RAA); s_rab = int'(RAB);
                    s_sel = int'(Sel); s_ctrl = int'(Ctrl);
                end
            end
            if (done) begin
                done_n++;
                done_cyc = i;
            end
            if (done && busy) both++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; Flag = 1'b0;
        instr_data = 24'h0;
        clear_rom();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd", instr_rd, 0);
        chk("rst_addr", instr_addr, 0);
        rst_n = 1'b1;
        step();

        // ALU then HALT
        rom[0] = i_alu(3'b000, 4'd3, 4'd1, 4'd2, 1'b1);
        rom[1] = i_k(3'b111, 8'h00);
        start_prog();
        chk("alu_busy0", busy, 1);
        run(8);
        chk("alu_wen_n", wen_n, 1);
        chk("alu_wen_cyc", wen_cyc, 2);
        chk("alu_op", s_op, 0);
        chk("alu_wa", s_wa, 3);
        chk("alu_raa", s_raa, 1);
        chk("alu_rab", s_rab, 2);
        chk("alu_ctrl", s_ctrl, 32'hA0);
        chk("alu_done_n", done_n, 1);
        chk("alu_done_cyc", done_cyc, 4);
        chk("alu_both", both, 0);
        chk("alu_busy_end", busy, 0);

        // reset in the middle of a long WAIT
        clear_rom();
        rom[0] = i_k(3'b100, 8'h20);
        rom[1] = i_k(3'b111, 8'h00);
        start_prog();
        repeat (5) step();
        chk("rw_busy", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rw_busy0", busy, 0);
        chk("rw_done0", done, 0);
        chk("rw_rd0", instr_rd, 0);
        chk("rw_wen0", Wen, 0);
        chk("rw_addr0", instr_addr, 0);
        chk("rw_wa0", WA, 0);
        chk("rw_raa0", RAA, 0);
        chk("rw_ctrl0", Ctrl, 0);
        step();
        start_prog();
        run(40);
        chk("rw_addr_first", qa(0), 0);
        chk("rw_addr_second", qa(1), 1);
        chk("rw_done_cyc", done_cyc, 36);

        // BRF taken
        clear_rom();
        rom[0]     = i_alu(3'b010, 4'd1, 4'd2, 4'd3, 1'b0);
        rom[1]     = i_k(3'b010, 8'h10);
        rom[2]     = i_k(3'b111, 8'h00);
        rom[8'h10] = i_k(3'b111, 8'h00);
        Flag = 1'b1;
        start_prog();
        run(10);
        chk("brf1_n", addrs.size(), 3);
        chk("brf1_a1", qa(1), 1);
        chk("brf1_a2", qa(2), 32'h10);
        chk("brf1_wen", wen_n, 0);
        chk("brf1_done", done_n, 1);

        // BRF not taken
        Flag = 1'b0;
        start_prog();
        run(10);
        chk("brf0_a2", qa(2), 2);
        chk("brf0_wen", wen_n, 0);

        // WAIT 5 between two ALUs
        clear_rom();
        rom[0] = i_alu(3'b001, 4'd4, 4'd5, 4'd6, 1'b1);
        rom[1] = i_k(3'b100, 8'd5);
        rom[2] = i_alu(3'b011, 4'd5, 4'd4, 4'd6, 1'b1);
        rom[3] = i_k(3'b111, 8'h00);
        start_prog();
        run(20);
        chk("w5_gap", qc(2) - qc(1), 7);
        chk("w5_wen", wen_n, 2);
        chk("w5_done_cyc", done_cyc, 13);

        // WAIT 0: no stall
        rom[1] = i_k(3'b100, 8'd0);
        start_prog();
        run(12);
        chk("w0_gap", qc(2) - qc(1), 2);
        chk("w0_done_cyc", done_cyc, 8);

        // JMP to 0xFF, IN there, pc wraps to 0
        clear_rom();
        rom[0]   = i_k(3'b011, 8'hFF);
        rom[255] = i_in(4'd7, 4'hA);
        start_prog();
        run(6);
        chk("jmp_a1", qa(1), 32'hFF);
        chk("jmp_a2", qa(2), 0);
        chk("jmp_wen_cyc", wen_cyc, 4);
        chk("jmp_sel", s_sel, 32'hA);
        chk("jmp_op", s_op, 4);
        chk("jmp_wa", s_wa, 7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("jmp_ab_busy", busy, 0);
        chk("jmp_ab_rd", instr_rd, 0);
        chk("jmp_ab_done", done, 0);

        // abort in the issue cycle of a write suppresses Wen
        clear_rom();
        rom[0] = i_alu(3'b101, 4'd9, 4'd1, 4'd1, 1'b1);
        rom[1] = i_k(3'b111, 8'h00);
        start_prog();
        step();
        step();
        abort = 1'b1;
        #1;
        chk("abw_wen", Wen, 0);
        step();
        abort = 1'b0;
        chk("abw_busy", busy, 0);

        // abort during FETCH of a HALT program
        clear_rom();
        rom[0] = i_k(3'b111, 8'h00);
        start_prog();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abh_busy", busy, 0);
        chk("abh_done", done, 0);
        chk("abh_wen", Wen, 0);
        start_prog();
        chk("abh_restart_rd", instr_rd, 1);
        run(6);
        chk("abh_done_cyc", done_cyc, 2);

        // start and abort together while idle
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_rd", instr_rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

endmodule
